// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes SD commands, answers R1/R3/R7
// and serves single 512-byte block reads/writes over a byte memory port.
module sd_spi_responder #(
  parameter int ADDR_W            = 20,
  parameter int INIT_ACMD41_COUNT = 2,
  parameter int NAC_BYTES         = 2,
  parameter int BUSY_BYTES        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        mem_wr_data,
  output logic              mem_we,
  output logic [5:0]        last_cmd,
  output logic              idle_o
);

  localparam logic [2:0] S_RX_CMD  = 3'd0;
  localparam logic [2:0] S_RESP    = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_WR_TOK  = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;

  localparam logic [15:0] RD_TOK  = 16'(NAC_BYTES);
  localparam logic [15:0] RD_DEND = 16'(NAC_BYTES + 513);
  localparam logic [15:0] RD_END  = 16'(NAC_BYTES + 514);
  localparam logic [15:0] WR_BUSY = 16'(BUSY_BYTES);
  localparam logic [7:0]  ACMD_N  = 8'(INIT_ACMD41_COUNT);

  logic cs_m_q, cs_s_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic mosi_m_q, mosi_s_q;

  logic [2:0]        state_q, state_d, nxt_q, nxt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [2:0]        ccnt_q, ccnt_d;
  logic [5:0]        cmd_q, cmd_d;
  logic [31:0]       arg_q, arg_d;
  logic [47:0]       resp_q, resp_d;
  logic [2:0]        rlast_q, rlast_d;
  logic              app_q, app_d;
  logic              idle_q, idle_d;
  logic [7:0]        acnt_q, acnt_d;
  logic [5:0]        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              we_q, we_d;

  logic        rise, fall, rx_done;
  logic [7:0]  rx_byte, acnt_inc;
  logic        dec_idle, dec_ill;
  logic [31:0] dec_tail;
  logic        unused_arg;

  assign rise     = ~cs_s_q & sclk_s_q & ~sclk_p_q;
  assign fall     = ~cs_s_q & ~sclk_s_q & sclk_p_q;
  assign rx_byte  = {rx_q, mosi_s_q};
  assign rx_done  = rise & (bit_q == 3'd7);
  assign acnt_inc = acnt_q + 8'd1;
  assign unused_arg = ^arg_q;

  assign miso        = tx_q[7];
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdat_q;
  assign mem_we      = we_q;
  assign last_cmd    = last_q;
  assign idle_o      = idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_m_q   <= 1'b1;
      cs_s_q   <= 1'b1;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      mosi_m_q <= 1'b1;
      mosi_s_q <= 1'b1;
    end else begin
      cs_m_q   <= cs;
      cs_s_q   <= cs_m_q;
      sclk_m_q <= sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      mosi_m_q <= mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    ccnt_d   = ccnt_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    resp_d   = resp_q;
    rlast_d  = rlast_q;
    app_d    = app_q;
    idle_d   = idle_q;
    acnt_d   = acnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    we_d     = 1'b0;
    dec_idle = idle_q;
    dec_ill  = 1'b0;
    dec_tail = 32'h0;
    // Step the write address once the strobe for the current byte is out
    if (we_q) addr_d[8:0] = addr_q[8:0] + 9'd1;
    if (cs_s_q) begin
      state_d = S_RX_CMD;
      bit_d   = 3'd0;
      ccnt_d  = 3'd0;
      tx_d    = 8'hFF;
    end else begin
      if (rise) begin
        bit_d = bit_q + 3'd1;
        rx_d  = rx_byte[6:0];
      end
      if (rx_done) begin
        unique case (state_q)
          S_RX_CMD: begin
            if (ccnt_q == 3'd0) begin
              if (rx_byte[7:6] == 2'b01) begin
                cmd_d  = rx_byte[5:0];
                ccnt_d = 3'd1;
              end
            end else if (ccnt_q != 3'd5) begin
              arg_d  = {arg_q[23:0], rx_byte};
              ccnt_d = ccnt_q + 3'd1;
            end else begin
              ccnt_d  = 3'd0;
              last_d  = cmd_q;
              app_d   = 1'b0;
              rlast_d = 3'd1;
              nxt_d   = S_RX_CMD;
              unique case (cmd_q)
                6'd0: begin
                  dec_idle = 1'b1;
                  acnt_d   = 8'd0;
                end
                6'd8: begin
                  dec_tail = {24'h000001, arg_q[7:0]};
                  rlast_d  = 3'd5;
                end
                6'd55: app_d = 1'b1;
                6'd41: begin
                  if (app_q) begin
                    if (acnt_q != 8'hFF) acnt_d = acnt_inc;
                    if (acnt_inc >= ACMD_N) dec_idle = 1'b0;
                  end else begin
                    dec_ill = 1'b1;
                  end
                end
                6'd58: begin
                  dec_tail = 32'hC0FF8000;
                  rlast_d  = 3'd5;
                end
                6'd16: ;
                6'd17, 6'd24: begin
                  if (idle_q) begin
                    dec_ill = 1'b1;
                  end else begin
                    nxt_d  = (cmd_q == 6'd17) ? S_RD : S_WR_TOK;
                    addr_d = {arg_q[ADDR_W-10:0], 9'd0};
                  end
                end
                default: dec_ill = 1'b1;
              endcase
              idle_d  = dec_idle;
              resp_d  = {8'hFF, 5'b0, dec_ill, 1'b0, dec_idle, dec_tail};
              state_d = S_RESP;
              cnt_d   = 16'd0;
            end
          end
          S_WR_TOK: begin
            if (rx_byte == 8'hFE) begin
              state_d = S_WR_DATA;
              cnt_d   = 16'd0;
            end
          end
          S_WR_DATA: begin
            if (cnt_q < 16'd512) begin
              we_d   = 1'b1;
              wdat_d = rx_byte;
            end
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd513) begin
              state_d = S_WR_RESP;
              cnt_d   = 16'd0;
            end
          end
          default: ;
        endcase
      end
      // Byte boundary: the falling edge after bit 0 loads the next byte
      if (fall) begin
        if (bit_q == 3'd0) begin
          tx_d = 8'hFF;
          unique case (state_q)
            S_RESP: begin
              tx_d   = resp_q[47:40];
              resp_d = resp_q << 8;
              cnt_d  = cnt_q + 16'd1;
              if (cnt_q[2:0] == rlast_q) begin
                state_d = nxt_q;
                cnt_d   = 16'd0;
              end
            end
            S_RD: begin
              if (cnt_q == RD_TOK) begin
                tx_d = 8'hFE;
              end else if (cnt_q > RD_TOK && cnt_q < RD_DEND) begin
                tx_d        = mem_rd_data;
                addr_d[8:0] = addr_q[8:0] + 9'd1;
              end
              cnt_d = cnt_q + 16'd1;
              if (cnt_q == RD_END) state_d = S_RX_CMD;
            end
            S_WR_RESP: begin
              tx_d  = (cnt_q == 16'd0) ? 8'h05 : 8'h00;
              cnt_d = cnt_q + 16'd1;
              if (cnt_q == WR_BUSY) state_d = S_RX_CMD;
            end
            default: ;
          endcase
        end else begin
          tx_d = {tx_q[6:0], 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RX_CMD;
      nxt_q   <= S_RX_CMD;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      rx_q    <= 7'd0;
      tx_q    <= 8'hFF;
      ccnt_q  <= 3'd0;
      cmd_q   <= 6'd0;
      arg_q   <= 32'd0;
      resp_q  <= 48'd0;
      rlast_q <= 3'd1;
      app_q   <= 1'b0;
      idle_q  <= 1'b1;
      acnt_q  <= 8'd0;
      last_q  <= 6'd0;
      addr_q  <= '0;
      wdat_q  <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      ccnt_q  <= ccnt_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      resp_q  <= resp_d;
      rlast_q <= rlast_d;
      app_q   <= app_d;
      idle_q  <= idle_d;
      acnt_q  <= acnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: command table plus
// hand-written block write, block read and mid-write abort sequences.
module tb_sd_spi_responder;

  localparam int AW   = 20;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          rst, cs, sclk, mosi;
  logic          miso;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data = 8'h00;
  logic [7:0]    mem_wr_data;
  logic          mem_we;
  logic [5:0]    last_cmd;
  logic          idle_o;

  sd_spi_responder #(
    .ADDR_W(AW),
    .INIT_ACMD41_COUNT(2),
    .NAC_BYTES(2),
    .BUSY_BYTES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_data(mem_wr_data),
    .mem_we(mem_we),
    .last_cmd(last_cmd),
    .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  int we_cnt = 0;
  int we_min = 1 << AW;
  int we_max = -1;

  always @(posedge clk) mem_rd_data <= mem[mem_addr];

  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wr_data;
      we_cnt++;
      if (int'(mem_addr) < we_min) we_min = int'(mem_addr);
      if (int'(mem_addr) > we_max) we_max = int'(mem_addr);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] exp);
    logic [7:0] r;
    xfer(8'hFF, r);
    chk(name, {24'h0, r}, {24'h0, exp});
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] a);
    logic [7:0] r;
    xfer({2'b01, c}, r);
    xfer(a[31:24], r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    xfer(8'h95, r);
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_hi();
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    int          n;
    logic [47:0] exp;
    logic        idle;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [7:0] r;
    int bad;

    vt[0] = '{6'd0,  32'h0,        2, 48'hFF01_0000_0000, 1'b1};
    vt[1] = '{6'd8,  32'h000001AA, 6, 48'hFF01_0000_01AA, 1'b1};
    vt[2] = '{6'd55, 32'h0,        2, 48'hFF01_0000_0000, 1'b1};
    vt[3] = '{6'd41, 32'h40000000, 2, 48'hFF01_0000_0000, 1'b1};
    vt[4] = '{6'd55, 32'h0,        2, 48'hFF01_0000_0000, 1'b1};
    vt[5] = '{6'd41, 32'h40000000, 2, 48'hFF00_0000_0000, 1'b0};
    vt[6] = '{6'd58, 32'h0,        6, 48'hFF00_C0FF_8000, 1'b0};
    vt[7] = '{6'd16, 32'h200,      2, 48'hFF00_0000_0000, 1'b0};
    vt[8] = '{6'd41, 32'h0,        2, 48'hFF04_0000_0000, 1'b0};
    vt[9] = '{6'd2,  32'h0,        2, 48'hFF04_0000_0000, 1'b0};

    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_miso", {31'h0, miso}, 32'h1);
    chk("rst_idle", {31'h0, idle_o}, 32'h1);
    chk("rst_last", {26'h0, last_cmd}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", {12'h0, mem_addr}, 32'h0);
    chk("rst_wdata", {24'h0, mem_wr_data}, 32'h0);

    for (int k = 0; k < 10; k++) begin
      cs_lo();
      send_cmd(vt[k].cmd, vt[k].arg);
      for (int i = 0; i < vt[k].n; i++) begin
        logic [47:0] e;
        e = vt[k].exp << (8 * i);
        rd_chk($sformatf("v%0d_b%0d", k, i), e[47:40]);
      end
      rd_chk($sformatf("v%0d_tail", k), 8'hFF);
      chk($sformatf("v%0d_idle", k), {31'h0, idle_o}, {31'h0, vt[k].idle});
      chk($sformatf("v%0d_last", k), {26'h0, last_cmd}, {26'h0, vt[k].cmd});
      cs_hi();
    end

    cs_lo();
    send_cmd(6'd24, 32'd3);
    rd_chk("wr_ncr", 8'hFF);
    rd_chk("wr_r1", 8'h00);
    xfer(8'hFF, r);
    xfer(8'hFF, r);
    xfer(8'hFE, r);
    for (int i = 0; i < 512; i++) xfer(8'(i), r);
    xfer(8'hAB, r);
    xfer(8'hCD, r);
    rd_chk("wr_dresp", 8'h05);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("wr_busy%0d", i), 8'h00);
    rd_chk("wr_tail", 8'hFF);
    cs_hi();
    chk("wr_count", we_cnt, 512);
    chk("wr_amin", we_min, 32'h600);
    chk("wr_amax", we_max, 32'h7FF);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[AW'(32'h600 + i)] !== 8'(i)) bad++;
    chk("wr_data", bad, 0);

    cs_lo();
    send_cmd(6'd17, 32'd3);
    rd_chk("rd_ncr", 8'hFF);
    rd_chk("rd_r1", 8'h00);
    rd_chk("rd_nac0", 8'hFF);
    rd_chk("rd_nac1", 8'hFF);
    rd_chk("rd_tok", 8'hFE);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      xfer(8'hFF, r);
      if (r !== 8'(i)) bad++;
    end
    chk("rd_data", bad, 0);
    rd_chk("rd_crc0", 8'hFF);
    rd_chk("rd_crc1", 8'hFF);
    rd_chk("rd_tail", 8'hFF);
    chk("rd_no_we", we_cnt, 512);
    cs_hi();

    we_cnt = 0;
    cs_lo();
    send_cmd(6'd24, 32'd5);
    rd_chk("ab_ncr", 8'hFF);
    rd_chk("ab_r1", 8'h00);
    xfer(8'hFE, r);
    for (int i = 0; i < 100; i++) xfer(8'hA0 ^ 8'(i), r);
    cs_hi();
    chk("ab_count", we_cnt, 100);
    chk("ab_miso", {31'h0, miso}, 32'h1);
    xfer(8'h12, r);
    xfer(8'h34, r);
    chk("ab_count2", we_cnt, 100);

    cs_lo();
    send_cmd(6'd0, 32'd0);
    rd_chk("ab_cmd0_ncr", 8'hFF);
    rd_chk("ab_cmd0_r1", 8'h01);
    cs_hi();
    chk("ab_idle", {31'h0, idle_o}, 32'h1);

    cs_lo();
    send_cmd(6'd17, 32'd0);
    rd_chk("idle_rd_ncr", 8'hFF);
    rd_chk("idle_rd_r1", 8'h05);
    rd_chk("idle_rd_tail", 8'hFF);
    cs_hi();
    chk("ab_count3", we_cnt, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
